// File: rtl/debounce_sync.sv
// Input conditioner: 2-flop synchronizer followed by a stability-count debouncer.
// Also keeps a saturating count of aborted qualifications for debug.
module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        INIT_LEVEL    = 1'b0,
  parameter int unsigned GCNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  input  logic              glitch_clr,
  output logic              data_out,
  output logic              busy,
  output logic [GCNT_W-1:0] glitch_cnt
);

  localparam int unsigned        CntW    = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0]    CntOne  = CntW'(1);
  localparam logic [CntW-1:0]    CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [GCNT_W-1:0]  GcntMax = '1;

  typedef enum logic [0:0] {StStable, StWait} state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic                out_q, out_d;
  logic                busy_q, busy_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic                bounce;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= INIT_LEVEL;
      sync2_q <= INIT_LEVEL;
      out_q   <= INIT_LEVEL;
      state_q <= StStable;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      gcnt_q  <= gcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    bounce  = 1'b0;
    unique case (state_q)
      StStable: begin
        if (sync2_q != out_q) begin
          state_d = StWait;
          cnt_d   = CntOne;
          busy_d  = 1'b1;
        end
      end
      StWait: begin
        // A sample agreeing with the output aborts the candidate, even on the final count.
        if (sync2_q == out_q) begin
          state_d = StStable;
          cnt_d   = '0;
          busy_d  = 1'b0;
          bounce  = 1'b1;
        end else if (cnt_q == CntLast) begin
          out_d   = ~out_q;
          state_d = StStable;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StStable;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    gcnt_d = gcnt_q;
    if (glitch_clr) begin
      gcnt_d = '0;
    end else if (bounce && (gcnt_q != GcntMax)) begin
      gcnt_d = gcnt_q + GCNT_W'(1);
    end
  end

  assign data_out   = out_q;
  assign busy       = busy_q;
  assign glitch_cnt = gcnt_q;

endmodule
